// File: rtl/reg_file_arbiter_pkg.sv
// Shared constants for the register-file arbiter: FSM state encoding and
// default register-file geometry.
package reg_file_arb_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef enum logic {
        REQUESTER_0 = 1'b0,
        REQUESTER_1 = 1'b1
    } requester_t;

endpackage

// File: rtl/reg_file_arbiter_if.sv
// Bundle of the two requester ports and the register-file side of the arbiter.
// The arbiter uses the slave view; clients and the register file see the master view.
interface reg_file_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  REQ0;
    logic                  REQ1;
    logic                  WE0;
    logic                  WE1;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic [DATA_WIDTH-1:0] WDATA0;
    logic [DATA_WIDTH-1:0] WDATA1;
    logic                  GNT0;
    logic                  GNT1;
    logic                  RVALID0;
    logic                  RVALID1;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  BUSY;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic [DATA_WIDTH-1:0] RF_RdData;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RF_RdData,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA, BUSY,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RF_RdData,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA, BUSY,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData
    );
endinterface

// File: rtl/reg_file.sv
// 8 x 16 register file with registered read port, as seen by the arbiter.
module Reg_File #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge CLK) begin
        if (WrEn) begin
            r_mem[Address] <= WrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data <= '0;
        end else if (RdEn && !WrEn) begin
            r_rd_data <= r_mem[Address];
        end
    end

    assign RdData = r_rd_data;
endmodule

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Two-way round-robin winner selection; purely combinational.
module rr_arb2
    import reg_file_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  requester_t i_last,
    output logic       o_valid,
    output requester_t o_winner
);
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = REQUESTER_0;
        if (i_req0 && i_req1) begin
            // Contention: whoever did not win last time goes now.
            o_winner = (i_last == REQUESTER_0) ? REQUESTER_1 : REQUESTER_0;
        end else if (i_req1) begin
            o_winner = REQUESTER_1;
        end
    end
endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter granting two clients one-cycle access to the register
// file, returning read data with a per-owner RVALID pulse.
module reg_file_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    reg_file_arbiter_if.slave  bus
);
    logic [1:0]            r_state;
    requester_t            r_last;
    requester_t            r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rvalid;

    logic       w_any_req;
    requester_t w_winner;
    logic       w_access;

    rr_arb2 u_rr_arb2 (
        .i_req0   (bus.REQ0),
        .i_req1   (bus.REQ1),
        .i_last   (r_last),
        .o_valid  (w_any_req),
        .o_winner (w_winner)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_last   <= REQUESTER_1;
            r_owner  <= REQUESTER_0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= ACCESS;
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        if (w_winner == REQUESTER_1) begin
                            r_we    <= bus.WE1;
                            r_addr  <= bus.ADDR1;
                            r_wdata <= bus.WDATA1;
                        end else begin
                            r_we    <= bus.WE0;
                            r_addr  <= bus.ADDR0;
                            r_wdata <= bus.WDATA0;
                        end
                    end
                end
                ACCESS: begin
                    r_state <= r_we ? IDLE : RESP;
                end
                RESP: begin
                    // Register file output is valid now, one cycle after RdEn.
                    r_rdata           <= bus.RF_RdData;
                    r_rvalid[r_owner] <= 1'b1;
                    r_state           <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_access = (r_state == ACCESS);

    assign bus.GNT0       = w_access && (r_owner == REQUESTER_0);
    assign bus.GNT1       = w_access && (r_owner == REQUESTER_1);
    assign bus.RF_WrEn    = w_access && r_we;
    assign bus.RF_RdEn    = w_access && !r_we;
    assign bus.RF_Address = w_access ? r_addr  : '0;
    assign bus.RF_WrData  = w_access ? r_wdata : '0;
    assign bus.RVALID0    = r_rvalid[0];
    assign bus.RVALID1    = r_rvalid[1];
    assign bus.RDATA      = r_rdata;
    assign bus.BUSY       = (r_state != IDLE);
endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter wired to Reg_File; inputs change and
// outputs are sampled on the falling clock edge.
module tb_reg_file_arbiter;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_file_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    Reg_File #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_rf (
        .CLK     (clk),
        .RST     (rst),
        .WrEn    (bus.RF_WrEn),
        .RdEn    (bus.RF_RdEn),
        .Address (bus.RF_Address),
        .WrData  (bus.RF_WrData),
        .RdData  (bus.RF_RdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.REQ0 = 0; bus.REQ1 = 0; bus.WE0 = 0; bus.WE1 = 0;
        bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;
    endtask

    task automatic do_reset();
        rst = 1; drive_idle();
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1; drive_idle();
        bus.REQ0 = 1; bus.REQ1 = 1; bus.WE0 = 1; bus.WE1 = 1;
        cyc();
        cyc();
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        total++; if ({bus.GNT0, bus.GNT1, bus.RVALID0, bus.RVALID1} !== 4'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {bus.GNT0, bus.GNT1, bus.RVALID0, bus.RVALID1}); end
        total++; if ({bus.RF_WrEn, bus.RF_RdEn} !== 2'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {bus.RF_WrEn, bus.RF_RdEn}); end
        total++; if (bus.RDATA !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", bus.RDATA); end
        total++; if ({bus.RF_Address, bus.RF_WrData} !== '0) begin bad++; $display("FAIL reset_rf_bus got=%h/%h exp=0/0", bus.RF_Address, bus.RF_WrData); end
        // Requests seen only in reset cycles must not be granted afterwards.
        rst = 0; drive_idle();
        cyc();
        total++; if ({bus.BUSY, bus.GNT0, bus.GNT1} !== 3'b0) begin bad++; $display("FAIL reset_req_ignored got=%b exp=000", {bus.BUSY, bus.GNT0, bus.GNT1}); end
        $display("txn reset done");
    endtask

    task automatic test_write_read();
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 3'd1; bus.WDATA0 = 16'h0003;
        cyc();
        total++; if ({bus.GNT0, bus.GNT1} !== 2'b10) begin bad++; $display("FAIL wr_gnt got=%b exp=10", {bus.GNT0, bus.GNT1}); end
        total++; if ({bus.RF_WrEn, bus.RF_RdEn} !== 2'b10) begin bad++; $display("FAIL wr_strobes got=%b exp=10", {bus.RF_WrEn, bus.RF_RdEn}); end
        total++; if (bus.RF_Address !== 3'd1) begin bad++; $display("FAIL wr_addr got=%0d exp=1", bus.RF_Address); end
        total++; if (bus.RF_WrData !== 16'h0003) begin bad++; $display("FAIL wr_data got=%h exp=0003", bus.RF_WrData); end
        bus.REQ0 = 0;
        cyc();
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL wr_idle_t2 got=%b exp=0", bus.BUSY); end
        $display("txn r0 write addr=1 data=0003");
        bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 3'd1;
        cyc();
        total++; if ({bus.GNT0, bus.RF_RdEn, bus.RF_WrEn} !== 3'b110) begin bad++; $display("FAIL rd_gnt_strobe got=%b exp=110", {bus.GNT0, bus.RF_RdEn, bus.RF_WrEn}); end
        bus.REQ0 = 0;
        cyc();
        total++; if ({bus.BUSY, bus.RF_RdEn, bus.RVALID0} !== 3'b100) begin bad++; $display("FAIL rd_resp got=%b exp=100", {bus.BUSY, bus.RF_RdEn, bus.RVALID0}); end
        total++; if (bus.RF_Address !== 3'd0) begin bad++; $display("FAIL rd_resp_addr got=%0d exp=0", bus.RF_Address); end
        cyc();
        total++; if ({bus.RVALID0, bus.RVALID1} !== 2'b10) begin bad++; $display("FAIL rd_rvalid got=%b exp=10", {bus.RVALID0, bus.RVALID1}); end
        total++; if (bus.RDATA !== 16'h0003) begin bad++; $display("FAIL rd_rdata got=%h exp=0003", bus.RDATA); end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rd_idle_t3 got=%b exp=0", bus.BUSY); end
        cyc();
        total++; if (bus.RVALID0 !== 1'b0 || bus.RDATA !== 16'h0003) begin bad++; $display("FAIL rd_pulse_hold got=%b/%h exp=0/0003", bus.RVALID0, bus.RDATA); end
        $display("txn r0 read addr=1 data=%h", bus.RDATA);
    endtask

    task automatic test_contention();
        do_reset();
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 3'd6; bus.WDATA0 = 16'h0033;
        bus.REQ1 = 1; bus.WE1 = 1; bus.ADDR1 = 3'd2; bus.WDATA1 = 16'h00AA;
        cyc();
        total++; if ({bus.GNT0, bus.GNT1} !== 2'b10) begin bad++; $display("FAIL cont_first got=%b exp=10", {bus.GNT0, bus.GNT1}); end
        total++; if ({bus.RF_Address, bus.RF_WrData} !== {3'd6, 16'h0033}) begin bad++; $display("FAIL cont_first_bus got=%0d/%h exp=6/0033", bus.RF_Address, bus.RF_WrData); end
        bus.REQ0 = 0;
        cyc();
        total++; if ({bus.BUSY, bus.GNT0, bus.GNT1} !== 3'b000) begin bad++; $display("FAIL cont_gap got=%b exp=000", {bus.BUSY, bus.GNT0, bus.GNT1}); end
        cyc();
        total++; if ({bus.GNT0, bus.GNT1} !== 2'b01) begin bad++; $display("FAIL cont_second got=%b exp=01", {bus.GNT0, bus.GNT1}); end
        total++; if ({bus.RF_Address, bus.RF_WrData} !== {3'd2, 16'h00AA}) begin bad++; $display("FAIL cont_second_bus got=%0d/%h exp=2/00aa", bus.RF_Address, bus.RF_WrData); end
        bus.REQ1 = 0;
        cyc();
        bus.REQ1 = 1; bus.WE1 = 0; bus.ADDR1 = 3'd2;
        cyc();
        total++; if (bus.GNT1 !== 1'b1) begin bad++; $display("FAIL cont_rd_gnt got=%b exp=1", bus.GNT1); end
        bus.REQ1 = 0;
        cyc();
        cyc();
        total++; if ({bus.RVALID0, bus.RVALID1} !== 2'b01 || bus.RDATA !== 16'h00AA) begin bad++; $display("FAIL cont_rd got=%b/%h exp=01/00aa", {bus.RVALID0, bus.RVALID1}, bus.RDATA); end
        $display("txn contention r0@6=0033 r1@2=00aa readback=%h", bus.RDATA);
    endtask

    task automatic test_fairness();
        int grants;
        logic exp_owner;
        grants = 0;
        exp_owner = 1'b0;
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 3'd4; bus.WDATA0 = 16'h1000;
        bus.REQ1 = 1; bus.WE1 = 1; bus.ADDR1 = 3'd5; bus.WDATA1 = 16'h2000;
        for (int i = 0; i < 12; i++) begin
            cyc();
            total++; if ((bus.GNT0 & bus.GNT1) !== 1'b0) begin bad++; $display("FAIL fair_exclusive cyc=%0d got=%b%b", i, bus.GNT0, bus.GNT1); end
            if (i % 2 == 0) begin
                total++; if ({bus.GNT0, bus.GNT1} !== {~exp_owner, exp_owner}) begin bad++; $display("FAIL fair_order grant=%0d got=%b%b exp_owner=%0d", grants, bus.GNT0, bus.GNT1, exp_owner); end
                $display("txn fair grant=%0d owner=%0d data=%h", grants, bus.GNT1, bus.RF_WrData);
                grants++;
                exp_owner = ~exp_owner;
                bus.WDATA0 = bus.WDATA0 + 16'h0001;
                bus.WDATA1 = bus.WDATA1 + 16'h0001;
            end else begin
                total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL fair_idle cyc=%0d got=%b exp=0", i, bus.BUSY); end
            end
            if (i == 10) begin
                bus.REQ0 = 0; bus.REQ1 = 0;
            end
        end
    endtask

    task automatic test_read_owner();
        int busy_cycles;
        busy_cycles = 0;
        bus.REQ1 = 1; bus.WE1 = 0; bus.ADDR1 = 3'd6;
        cyc();
        total++; if ({bus.GNT0, bus.GNT1} !== 2'b01) begin bad++; $display("FAIL own_gnt got=%b exp=01", {bus.GNT0, bus.GNT1}); end
        bus.REQ1 = 0;
        if (bus.BUSY) busy_cycles++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.BUSY) busy_cycles++;
            if (i == 1) begin
                total++; if ({bus.RVALID0, bus.RVALID1} !== 2'b01) begin bad++; $display("FAIL own_rvalid got=%b exp=01", {bus.RVALID0, bus.RVALID1}); end
                total++; if (bus.RDATA !== 16'h0033) begin bad++; $display("FAIL own_rdata got=%h exp=0033", bus.RDATA); end
            end
        end
        total++; if (busy_cycles !== 2) begin bad++; $display("FAIL own_busy_len got=%0d exp=2", busy_cycles); end
        $display("txn r1 read addr=6 data=%h", bus.RDATA);
    endtask

    task automatic test_reset_mid_read();
        bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 3'd1;
        cyc();
        total++; if (bus.GNT0 !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", bus.GNT0); end
        bus.REQ0 = 0;
        cyc();
        total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL rmid_in_resp got=%b exp=1", bus.BUSY); end
        rst = 1;
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 3'd7; bus.WDATA0 = 16'h0077;
        bus.REQ1 = 1; bus.WE1 = 1; bus.ADDR1 = 3'd0; bus.WDATA1 = 16'h0100;
        cyc();
        total++; if ({bus.BUSY, bus.RVALID0, bus.RVALID1} !== 3'b000) begin bad++; $display("FAIL rmid_state got=%b exp=000", {bus.BUSY, bus.RVALID0, bus.RVALID1}); end
        total++; if (bus.RDATA !== 16'h0000) begin bad++; $display("FAIL rmid_rdata got=%h exp=0000", bus.RDATA); end
        rst = 0;
        cyc();
        total++; if ({bus.GNT0, bus.GNT1} !== 2'b10) begin bad++; $display("FAIL rmid_after_gnt got=%b exp=10", {bus.GNT0, bus.GNT1}); end
        total++; if ({bus.RVALID0, bus.RVALID1} !== 2'b00) begin bad++; $display("FAIL rmid_no_rvalid got=%b exp=00", {bus.RVALID0, bus.RVALID1}); end
        bus.REQ0 = 0;
        cyc();
        cyc();
        total++; if ({bus.GNT0, bus.GNT1} !== 2'b01) begin bad++; $display("FAIL rmid_second got=%b exp=01", {bus.GNT0, bus.GNT1}); end
        bus.REQ1 = 0;
        cyc();
        $display("txn reset during read, then r0@7 and r1@0 writes");
    endtask

    task automatic test_held_request();
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 3'd3; bus.WDATA0 = 16'h0055;
        cyc();
        total++; if (bus.GNT0 !== 1'b1) begin bad++; $display("FAIL held_first got=%b exp=1", bus.GNT0); end
        cyc();
        total++; if ({bus.GNT0, bus.BUSY} !== 2'b00) begin bad++; $display("FAIL held_gap got=%b exp=00", {bus.GNT0, bus.BUSY}); end
        cyc();
        total++; if ({bus.GNT0, bus.RF_WrEn} !== 2'b11) begin bad++; $display("FAIL held_dup got=%b exp=11", {bus.GNT0, bus.RF_WrEn}); end
        bus.REQ0 = 0;
        cyc();
        cyc();
        total++; if ({bus.GNT0, bus.BUSY} !== 2'b00) begin bad++; $display("FAIL held_done got=%b exp=00", {bus.GNT0, bus.BUSY}); end
        $display("txn r0 held request, duplicate write addr=3");
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_contention();
        test_fairness();
        test_read_owner();
        test_reset_mid_read();
        test_held_request();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
